// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of dmem_arbiter, grouped into one bundle.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (port 0) and DMA (port 1):
// fixed CPU priority with a streak limit that forces a DMA grant.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate and latch the winner's command
// ACCESS | memory command driven for MEM_LAT cycles; read data on the last
// RESP   | one-cycle ack to the owner, then back to IDLE
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    dmem_arbiter_if.slave bus,
    output logic          o_cpu_stall,
    output logic          o_owner,
    output logic          o_busy
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_WAIT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_owner;
    logic [3:0]        r_streak;
    logic [3:0]        r_lat_cnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic              r_cpu_ack;
    logic              r_dma_ack;

    logic w_any_req;
    logic w_grant_dma;
    logic w_last;

    assign w_any_req   = bus.cpu_req | bus.dma_req;
    // DMA wins when alone, or when the CPU has used up its contested streak.
    assign w_grant_dma = bus.dma_req & (~bus.cpu_req | (r_streak == STREAK_MAX));
    assign w_last      = (r_lat_cnt == 4'd1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_last)    w_state_nxt = S_RESP;
            S_RESP:                  w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_streak    <= 4'd0;
            r_lat_cnt   <= 4'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_grant_dma;
                        r_lat_cnt   <= LAT_LOAD;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_grant_dma ? bus.dma_we    : bus.cpu_we;
                        r_mem_addr  <= w_grant_dma ? bus.dma_addr  : bus.cpu_addr;
                        r_mem_wdata <= w_grant_dma ? bus.dma_wdata : bus.cpu_wdata;
                        r_streak    <= (!w_grant_dma && bus.dma_req) ? r_streak + 4'd1 : 4'd0;
                    end
                end
                S_ACCESS: begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                    if (w_last) begin
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        if (!r_mem_we) begin
                            if (r_owner) r_dma_rdata <= bus.mem_rdata;
                            else         r_cpu_rdata <= bus.mem_rdata;
                        end
                        if (r_owner) r_dma_ack <= 1'b1;
                        else         r_cpu_ack <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.dma_rdata = r_dma_rdata;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.dma_ack   = r_dma_ack;

    assign o_cpu_stall = bus.cpu_req & ~r_cpu_ack;
    assign o_owner     = r_owner;
    assign o_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each with a small word memory behind its port.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_a_n, rst_b_n;
    logic a_stall, a_owner, a_busy;
    logic b_stall, b_owner, b_busy;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    bit   [9:0]  fair_dma = 10'b10000_10000;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(4)) u_a (
        .i_clk(clk), .i_rst_n(rst_a_n), .bus(a_if),
        .o_cpu_stall(a_stall), .o_owner(a_owner), .o_busy(a_busy));

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_b_n), .bus(b_if),
        .o_cpu_stall(b_stall), .o_owner(b_owner), .o_busy(b_busy));

    assign a_if.mem_rdata = mem_a[a_if.mem_addr[7:2]];
    assign b_if.mem_rdata = mem_b[b_if.mem_addr[7:2]];

    always @(posedge clk) begin
        if (!rst_a_n)                        mem_a[16] <= 32'hDEADBEEF;
        else if (a_if.mem_en && a_if.mem_we) mem_a[a_if.mem_addr[7:2]] <= a_if.mem_wdata;
        if (b_if.mem_en && b_if.mem_we)      mem_b[b_if.mem_addr[7:2]] <= b_if.mem_wdata;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        a_if.cpu_req = 0; a_if.cpu_we = 0; a_if.cpu_addr = 0; a_if.cpu_wdata = 0;
        a_if.dma_req = 0; a_if.dma_we = 0; a_if.dma_addr = 0; a_if.dma_wdata = 0;
        b_if.cpu_req = 0; b_if.cpu_we = 0; b_if.cpu_addr = 0; b_if.cpu_wdata = 0;
        b_if.dma_req = 0; b_if.dma_we = 0; b_if.dma_addr = 0; b_if.dma_wdata = 0;
        cyc(); cyc();
        chk1 ("rst_mem_en", a_if.mem_en, 1'b0);
        chk1 ("rst_busy",   a_busy,      1'b0);
        chk1 ("rst_owner",  a_owner,     1'b0);
        chk32("rst_rdata",  a_if.cpu_rdata, 32'h0);
        chk32("rst_addr_b", b_if.mem_addr,  32'h0);
        chk1 ("rst_ack_b",  b_if.dma_ack,   1'b0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // single CPU read, MEM_LAT=1
        cyc(); a_if.cpu_req = 1; a_if.cpu_we = 0; a_if.cpu_addr = 32'h40; #1;
        chk1 ("t1_c0_stall", a_stall,     1'b1);
        chk1 ("t1_c0_en",    a_if.mem_en, 1'b0);
        cyc();
        chk1 ("t1_c1_en",    a_if.mem_en,   1'b1);
        chk32("t1_c1_addr",  a_if.mem_addr, 32'h40);
        chk1 ("t1_c1_stall", a_stall,       1'b1);
        chk1 ("t1_c1_ack",   a_if.cpu_ack,  1'b0);
        cyc();
        chk1 ("t1_c2_ack",   a_if.cpu_ack,   1'b1);
        chk32("t1_c2_rdata", a_if.cpu_rdata, 32'hDEADBEEF);
        chk1 ("t1_c2_stall", a_stall,        1'b0);
        chk1 ("t1_c2_dack",  a_if.dma_ack,   1'b0);
        cyc(); a_if.cpu_req = 0; #1;
        chk1 ("t1_c3_ack",  a_if.cpu_ack, 1'b0);
        chk1 ("t1_c3_busy", a_busy,       1'b0);
        chk1 ("t1_c3_en",   a_if.mem_en,  1'b0);

        // DMA write then CPU read-back, MEM_LAT=3
        cyc(); b_if.dma_req = 1; b_if.dma_we = 1; b_if.dma_addr = 32'h80; b_if.dma_wdata = 32'h12345678; #1;
        cyc();
        chk1 ("t2_c1_en",    b_if.mem_en,    1'b1);
        chk1 ("t2_c1_we",    b_if.mem_we,    1'b1);
        chk32("t2_c1_wdata", b_if.mem_wdata, 32'h12345678);
        chk32("t2_c1_addr",  b_if.mem_addr,  32'h80);
        cyc(); b_if.dma_addr = 32'h84; b_if.dma_wdata = 32'h0; #1;
        chk1 ("t2_c2_we",    b_if.mem_we,    1'b1);
        chk32("t2_c2_addr",  b_if.mem_addr,  32'h80);
        chk32("t2_c2_wdata", b_if.mem_wdata, 32'h12345678);
        cyc();
        chk1 ("t2_c3_we",   b_if.mem_we,  1'b1);
        chk1 ("t2_c3_dack", b_if.dma_ack, 1'b0);
        cyc();
        chk1 ("t2_c4_dack",  b_if.dma_ack, 1'b1);
        chk1 ("t2_c4_cack",  b_if.cpu_ack, 1'b0);
        chk1 ("t2_c4_we",    b_if.mem_we,  1'b0);
        chk1 ("t2_c4_en",    b_if.mem_en,  1'b0);
        chk1 ("t2_c4_owner", b_owner,      1'b1);
        cyc(); b_if.dma_req = 0; b_if.cpu_req = 1; b_if.cpu_we = 0; b_if.cpu_addr = 32'h80; #1;
        cyc();
        chk1 ("t2_c6_en",    b_if.mem_en, 1'b1);
        chk1 ("t2_c6_we",    b_if.mem_we, 1'b0);
        chk1 ("t2_c6_owner", b_owner,     1'b0);
        cyc(); cyc();
        chk1 ("t2_c8_ack", b_if.cpu_ack, 1'b0);
        cyc();
        chk1 ("t2_c9_ack",    b_if.cpu_ack,   1'b1);
        chk32("t2_c9_rdata",  b_if.cpu_rdata, 32'h12345678);
        chk32("t2_c9_drdata", b_if.dma_rdata, 32'h0);

        // simultaneous request, streak 0: CPU first, DMA ack MEM_LAT+2 later
        cyc(); b_if.dma_req = 1; b_if.dma_we = 0; b_if.dma_addr = 32'h80; #1;
        cyc(); cyc(); cyc(); cyc();
        chk1 ("t3_cack", b_if.cpu_ack, 1'b1);
        chk1 ("t3_dack_early", b_if.dma_ack, 1'b0);
        cyc(); b_if.cpu_req = 0; #1;
        cyc(); cyc(); cyc();
        chk1 ("t3_dack_c18", b_if.dma_ack, 1'b0);
        cyc();
        chk1 ("t3_dack",   b_if.dma_ack,   1'b1);
        chk32("t3_drdata", b_if.dma_rdata, 32'h12345678);
        chk1 ("t3_owner",  b_owner,        1'b1);

        // reset in the second ACCESS cycle, request held across it
        cyc(); b_if.dma_req = 0; b_if.cpu_req = 1; b_if.cpu_addr = 32'h80; #1;
        cyc();
        chk1 ("t4_c1_en", b_if.mem_en, 1'b1);
        cyc(); rst_b_n = 1'b0; #1;
        chk1 ("t4_rst_en",    b_if.mem_en,    1'b0);
        chk1 ("t4_rst_we",    b_if.mem_we,    1'b0);
        chk1 ("t4_rst_busy",  b_busy,         1'b0);
        chk1 ("t4_rst_ack",   b_if.cpu_ack,   1'b0);
        chk32("t4_rst_rdata", b_if.cpu_rdata, 32'h0);
        chk32("t4_rst_drd",   b_if.dma_rdata, 32'h0);
        chk32("t4_rst_addr",  b_if.mem_addr,  32'h0);
        chk32("t4_rst_wdata", b_if.mem_wdata, 32'h0);
        chk1 ("t4_rst_owner", b_owner,        1'b0);
        cyc(); rst_b_n = 1'b1; #1;
        chk1 ("t4_c3_busy", b_busy, 1'b0);
        cyc();
        chk1 ("t4_c4_en", b_if.mem_en, 1'b1);
        cyc(); cyc();
        chk1 ("t4_c6_ack", b_if.cpu_ack, 1'b0);
        cyc();
        chk1 ("t4_c7_ack",   b_if.cpu_ack,   1'b1);
        chk32("t4_c7_rdata", b_if.cpu_rdata, 32'h12345678);
        cyc(); b_if.cpu_req = 0; #1;

        // fairness with MAX_WAIT=4: C C C C D repeating
        cyc();
        a_if.cpu_req = 1; a_if.cpu_we = 0; a_if.cpu_addr = 32'h40;
        a_if.dma_req = 1; a_if.dma_we = 0; a_if.dma_addr = 32'h40; #1;
        for (int g = 0; g < 10; g++) begin
            cyc(); cyc();
            chk1($sformatf("fair_cack_%0d", g), a_if.cpu_ack, ~fair_dma[g]);
            chk1($sformatf("fair_dack_%0d", g), a_if.dma_ack, fair_dma[g]);
            chk1($sformatf("fair_own_%0d", g),  a_owner,      fair_dma[g]);
            cyc();
        end
        a_if.cpu_req = 0; a_if.dma_req = 0; #1;

        // CPU write leaves cpu_rdata unchanged
        cyc(); a_if.cpu_req = 1; a_if.cpu_we = 1; a_if.cpu_addr = 32'h44; a_if.cpu_wdata = 32'h55; #1;
        cyc();
        chk1 ("t6_c1_we", a_if.mem_we, 1'b1);
        cyc();
        chk1 ("t6_c2_ack",   a_if.cpu_ack,   1'b1);
        chk32("t6_c2_rdata", a_if.cpu_rdata, 32'hDEADBEEF);
        cyc(); a_if.cpu_req = 0; #1;

        // request dropped during ACCESS still completes exactly once
        cyc(); a_if.cpu_req = 1; a_if.cpu_we = 0; a_if.cpu_addr = 32'h44; #1;
        cyc(); a_if.cpu_req = 0; #1;
        chk1 ("t7_c1_en",    a_if.mem_en, 1'b1);
        chk1 ("t7_c1_stall", a_stall,     1'b0);
        cyc();
        chk1 ("t7_c2_ack",   a_if.cpu_ack,   1'b1);
        chk32("t7_c2_rdata", a_if.cpu_rdata, 32'h55);
        cyc();
        chk1 ("t7_c3_busy", a_busy,       1'b0);
        chk1 ("t7_c3_ack",  a_if.cpu_ack, 1'b0);
        cyc();
        chk1 ("t7_c4_en",   a_if.mem_en,  1'b0);
        chk1 ("t7_c4_busy", a_busy,       1'b0);
        chk1 ("t7_c4_ack",  a_if.cpu_ack, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
